// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: 2^AW 32-bit words with byte/halfword/word writes and zero-wait, forwarded reads.
// Build option: define AHB_SRAM_WAIT_EN to insert one wait state ahead of every valid beat.
module ahb_sram_slave #(
    parameter int AW = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADYOUT
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCESS = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_ERR1   = 3'd3;
    localparam logic [2:0] ST_ERR2   = 3'd4;

`ifdef AHB_SRAM_WAIT_EN
    localparam logic [2:0] ST_BEAT = ST_WAIT;
`else
    localparam logic [2:0] ST_BEAT = ST_ACCESS;
`endif

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [AW-1:0] addr_q;
    logic [1:0]    lane_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [2**AW];

    logic          accept;
    logic          xfer_ok;
    logic          do_write;
    logic [AW-1:0] haddr_word;
    logic [3:0]    be_q;
    logic          unused_ok;

    // Burst type and the BUSY/IDLE distinction carry no meaning for a flat SRAM.
    assign unused_ok  = ^{HBURST, HTRANS[0]};
    assign haddr_word = HADDR[AW+1:2];

    // ERR1 and WAIT drive HREADYOUT low, so nothing presented then may be taken.
    assign accept = HSEL && HREADY && HTRANS[1] &&
                    (state != ST_ERR1) && (state != ST_WAIT);

    always_comb begin
        xfer_ok = 1'b1;
        if (HSIZE > 3'd2)
            xfer_ok = 1'b0;
        if ((HSIZE == 3'd1) && HADDR[0])
            xfer_ok = 1'b0;
        if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
            xfer_ok = 1'b0;
        if (HADDR[31:AW+2] != '0)
            xfer_ok = 1'b0;
    end

    always_comb begin
        case (size_q)
            3'd0:    be_q = 4'b0001 << lane_q;
            3'd1:    be_q = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be_q = 4'b1111;
        endcase
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_WAIT: state_nxt = ST_ACCESS;
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                if (accept)
                    state_nxt = xfer_ok ? ST_BEAT : ST_ERR1;
            end
        endcase
    end

`ifndef AHB_SRAM_WAIT_EN
    logic [31:0] wmask_q;
    logic [31:0] fwd_word;
    logic        fwd_hit;

    always_comb begin
        wmask_q = '0;
        for (int unsigned i = 0; i < 4; i++)
            wmask_q[8*i +: 8] = {8{be_q[i]}};
    end

    // A read addressed while the same word is being written sees the merged result.
    assign fwd_hit  = (state == ST_ACCESS) && write_q && (addr_q == haddr_word);
    assign fwd_word = (mem[haddr_word] & ~wmask_q) | (HWDATA & wmask_q);
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= haddr_word;
                lane_q  <= HADDR[1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
`ifdef AHB_SRAM_WAIT_EN
            if ((state == ST_WAIT) && !write_q)
                rdata_q <= mem[addr_q];
`else
            if (accept && xfer_ok && !HWRITE)
                rdata_q <= fwd_hit ? fwd_word : mem[haddr_word];
`endif
        end
    end

    // Memory has no reset; the reset term keeps an aborted data phase from committing.
    assign do_write = HRESETn && (state == ST_ACCESS) && write_q;

    always_ff @(posedge HCLK) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i])
                    mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = (state != ST_ERR1) && (state != ST_WAIT);
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
    assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized scoreboard bench for ahb_sram_slave against a word-array reference model.
module tb_ahb_sram_slave;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef AHB_SRAM_WAIT_EN
    localparam int OK_WAITS = 1;
`else
    localparam int OK_WAITS = 0;
`endif
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADYOUT;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_sram_slave #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .HREADYOUT (HREADYOUT)
    );

    typedef struct packed {
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [DEPTH];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] dp_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic xfer_valid(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2)
            return 1'b0;
        if ((a % (32'd1 << s)) != 32'd0)
            return 1'b0;
        return a < 32'(4 * DEPTH);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int w;
        int lane;
        w = int'(a / 4);
        for (int b = 0; b < (1 << s); b++) begin
            lane = int'(a % 4) + b;
            model[w][8*lane +: 8] = d[8*lane +: 8];
        end
    endtask

    // One address-phase slot; held until the slave is ready, then expectations are queued.
    task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                             input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
        int   guard;
        logic taken;
        exp_t e;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        HBURST = 3'($urandom);
        HWDATA = dp_wdata;
        guard  = 0;
        @(negedge HCLK);
        while (!HREADYOUT && guard < 8) begin
            guard++;
            @(negedge HCLK);
        end
        if (!HREADYOUT) begin
            tests++;
            fails++;
            $display("FAIL hready_timeout: HREADYOUT stuck at 0, required 1 within 8 cycles");
        end
        taken = sel && trans[1];
        if (taken) begin
            e.rd   = !wr;
            e.err  = !xfer_valid(addr, size);
            e.data = '0;
            if (!e.err) begin
                if (wr)
                    model_write(addr, size, wdata);
                else
                    e.data = model[addr[AW+1:2]];
            end
            exp_q.push_back(e);
        end
        @(posedge HCLK);
        #1;
        dp_wdata = taken ? wdata : $urandom;
    endtask

    task automatic idle_cycle();
        bus_cycle(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    // Monitor: follows data phases and retires scoreboard entries as they complete.
    logic        dp_active = 1'b0;
    logic        dp_read   = 1'b0;
    int          dp_waits  = 0;
    logic [1:0]  wait_resp = 2'b00;
    logic [31:0] prev_rdata = '0;

    always @(negedge HCLK) begin
        logic in_read;
        exp_t e;
        if (!HRESETn) begin
            dp_active  = 1'b0;
            prev_rdata = HRDATA;
        end else begin
            in_read = dp_active && dp_read;
            if (dp_active) begin
                if (!HREADYOUT) begin
                    dp_waits++;
                    wait_resp = HRESP;
                end else begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard_underflow: data phase completed, none expected");
                    end else begin
                        e = exp_q.pop_front();
                        check("wait_cycles", 32'(dp_waits), e.err ? 32'd1 : 32'(OK_WAITS));
                        check("hresp", 32'(HRESP), e.err ? 32'd1 : 32'd0);
                        if (dp_waits > 0)
                            check("wait_hresp", 32'(wait_resp), e.err ? 32'd1 : 32'd0);
                        if (e.rd && !e.err)
                            check("hrdata", HRDATA, e.data);
                    end
                    dp_active = 1'b0;
                end
            end else begin
                check("idle_hreadyout", 32'(HREADYOUT), 32'd1);
                check("idle_hresp", 32'(HRESP), 32'd0);
            end
            if (!in_read)
                check("hrdata_hold", HRDATA, prev_rdata);
            prev_rdata = HRDATA;
            if (HREADYOUT && HSEL && HTRANS[1]) begin
                dp_active = 1'b1;
                dp_read   = !HWRITE;
                dp_waits  = 0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] last_addr;
        logic [2:0]  s;
        logic [31:0] saved2;
        logic [31:0] saved3;
        int          r;
        int          guard;

        HRESETn  = 1'b0;
        HSEL     = 1'b0;
        HTRANS   = T_IDLE;
        HWRITE   = 1'b0;
        HADDR    = '0;
        HWDATA   = '0;
        HSIZE    = '0;
        HBURST   = '0;
        dp_wdata = '0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;

        // Word write/read, then byte write followed directly by a forwarded read.
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 32'h11, 3'd0, 32'h0000AA00);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
        idle_cycle();

        // INCR4 writes then reads, back to back.
        for (int i = 0; i < 4; i++)
            bus_cycle(1'b1, (i == 0) ? T_NONSEQ : T_SEQ, 1'b1, 32'h20 + 32'(4*i), 3'd2, 32'(i + 1));
        for (int i = 0; i < 4; i++)
            bus_cycle(1'b1, (i == 0) ? T_NONSEQ : T_SEQ, 1'b0, 32'h20 + 32'(4*i), 3'd2, 32'h0);
        idle_cycle();

        // Error responses: misaligned, out of range, oversize; memory must be untouched.
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 32'h02, 3'd2, 32'h0);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 32'(4*DEPTH), 3'd2, 32'h0);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 32'h22, 3'd2, 32'hBAD0BAD0);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 32'(4*DEPTH) + 32'h20, 3'd2, 32'hBAD1BAD1);
        bus_cycle(1'b1, T_NONSEQ, 1'b1, 32'h20, 3'd3, 32'hBAD2BAD2);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 32'h20, 3'd2, 32'h0);
        bus_cycle(1'b1, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
        idle_cycle();

        // Fill every word so random reads always have a known value.
        for (int w = 0; w < DEPTH; w++)
            bus_cycle(1'b1, (w == 0) ? T_NONSEQ : T_SEQ, 1'b1, 32'(4*w), 3'd2, $urandom);

        last_addr = 32'h0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                bus_cycle(1'($urandom), 2'($urandom_range(0, 1)), 1'($urandom),
                          32'(4 * $urandom_range(0, DEPTH - 1)), 3'd2, $urandom);
            end else if (r == 1) begin
                bus_cycle(1'b0, T_NONSEQ, 1'($urandom), 32'h40, 3'd2, $urandom);
            end else begin
                s = 3'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 0)
                    a = {last_addr[31:2], 2'b00};
                else
                    a = 32'(4 * $urandom_range(0, DEPTH - 1));
                if (s == 3'd0)
                    a = a + 32'($urandom_range(0, 3));
                else if (s == 3'd1)
                    a = a + 32'(2 * $urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       s = 3'($urandom_range(3, 7));
                        1:       begin s = 3'd2; a = a | 32'($urandom_range(1, 3)); end
                        default: a = a | (32'($urandom_range(1, 255)) << (AW + 2));
                    endcase
                end
                last_addr = a;
                bus_cycle(1'b1, ($urandom_range(0, 1) == 0) ? T_NONSEQ : T_SEQ,
                          1'($urandom), a, s, $urandom);
            end
        end
        idle_cycle();
        idle_cycle();

        // Reset during the third beat of an INCR4 write: that beat must not land.
        saved2 = model[18];
        saved3 = model[19];
        for (int i = 0; i < 3; i++)
            bus_cycle(1'b1, (i == 0) ? T_NONSEQ : T_SEQ, 1'b1, 32'h40 + 32'(4*i), 3'd2,
                      32'hA5A50000 + 32'(i));
        HRESETn = 1'b0;
        exp_q.delete();
        model[18] = saved2;
        model[19] = saved3;
        HSEL   = 1'b0;
        HTRANS = T_IDLE;
        #2;
        check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("midrst_hresp", 32'(HRESP), 32'd0);
        check("midrst_hrdata", HRDATA, 32'h0);
        @(negedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn  = 1'b1;
        dp_wdata = $urandom;
        for (int i = 0; i < 4; i++)
            bus_cycle(1'b1, (i == 0) ? T_NONSEQ : T_SEQ, 1'b0, 32'h40 + 32'(4*i), 3'd2, 32'h0);
        idle_cycle();
        idle_cycle();

        guard = 0;
        while ((exp_q.size() != 0 || dp_active) && guard < 10) begin
            guard++;
            @(negedge HCLK);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter AW, default 8, meaning word-address width (memory depth 2^AW 32-bit words, byte range 0 .. 4*2^AW-1).
REQ-002 SHALL have port HCLK  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port HSEL  input  1  slave select.
REQ-005 SHALL have port HTRANS  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 SHALL have port HREADY  input  1  bus ready, previous data phase complete.
REQ-007 SHALL have port HWRITE  input  1  1=write, 0=read.
REQ-008 SHALL have port HADDR  input  32  byte address.
REQ-009 SHALL have port HWDATA  input  32  write data, data phase.
REQ-010 SHALL have port HSIZE  input  3  0=byte, 1=halfword, 2=word.
REQ-011 SHALL have port HBURST  input  3  burst type; informational only, not decoded.
REQ-012 SHALL have port HRDATA  output  32  read data.
REQ-013 SHALL have port HRESP  output  2  OKAY=00, ERROR=01; RETRY/SPLIT never driven.
REQ-014 SHALL have port HREADYOUT  output  1  slave ready.

Function
REQ-015 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ); it registers HADDR, HWRITE and HSIZE at that edge.
REQ-016 SHALL answer IDLE, BUSY and unselected cycles with zero-wait OKAY and no memory access.
REQ-017 SHALL use FSM states IDLE, ACCESS, WAIT, ERR1, ERR2.
REQ-018 Valid accepted transfer -> ACCESS (or WAIT when the REQ-029 feature is compiled in); invalid -> ERR1; otherwise -> IDLE.
REQ-019 ACCESS: HREADYOUT=1, HRESP=00; a write stores HWDATA at the end of this cycle, a read presents data on HRDATA during this cycle.
REQ-020 Byte-lane writes: byte updates lane HADDR[1:0]; halfword updates lanes 2*HADDR[1] and 2*HADDR[1]+1; word updates all; other lanes unchanged.
REQ-021 Reads SHALL return the full 32-bit word containing the address (lane selection is the master's).
REQ-022 Reads SHALL be zero-wait: the word is fetched at the address-phase edge and registered into HRDATA.
REQ-023 A read whose address phase coincides with a write data phase to the same word SHALL return the byte-merged new data (write forwarding), never stale data.
REQ-024 Invalid transfer: HSIZE>2, address misaligned to HSIZE, or HADDR[31:AW+2] nonzero.
REQ-025 Error response is two cycles: ERR1 drives HRESP=01 with HREADYOUT=0; ERR2 drives HRESP=01 with HREADYOUT=1; no memory write occurs.
REQ-026 Address phases presented during ERR1 SHALL be ignored; those presented during ERR2 SHALL be accepted normally.
REQ-027 SEQ beats SHALL be handled identically to NONSEQ; back-to-back beats SHALL sustain one beat per cycle when the REQ-029 feature is compiled out.
REQ-028 HRDATA SHALL hold its last value outside read data phases.

Configuration
REQ-029 Macro AHB_SRAM_WAIT_EN: when defined, every valid beat first spends one cycle in WAIT (HREADYOUT=0, HRESP=00), then moves to ACCESS, and the read data is valid in ACCESS; when undefined, the WAIT state is never entered and all valid beats are zero-wait.

Reset
REQ-030 While HRESETn=0: FSM=IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, registered address/control cleared.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset asserted mid-burst or mid-error SHALL abort immediately; a pending write data phase SHALL NOT be committed.

Verification
REQ-033 Word write 0x00000010 <- 0xDEADBEEF, then word read 0x10 -> HRDATA=0xDEADBEEF, HRESP=00, zero waits (macro off).
REQ-034 Byte write 0x11 <- 0x0000AA00 over 0xDEADBEEF, then immediate back-to-back read of 0x10 -> 0xDEADAAEF (forwarding).
REQ-035 INCR4 word writes at 0x20..0x2C with data 1..4, then INCR4 reads -> 1,2,3,4 in four consecutive cycles, HREADYOUT constantly 1.
REQ-036 Word read at 0x02 (misaligned) or at 4*2^AW -> HRESP=01/HREADYOUT=0 then HRESP=01/HREADYOUT=1; memory unchanged.
REQ-037 With AHB_SRAM_WAIT_EN defined, a single read -> HREADYOUT low exactly one cycle, data valid on the following cycle; HRESETn pulsed low mid-INCR4 write -> outputs reset values, interrupted beat not written.
